// File: rtl/ps2_pkg.sv
// ps2_pkg: frame FSM state encoding and keyboard scan-code constants shared by the PS/2 receiver.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes and deglitches the PS/2 pins and assembles 11-bit frames into bytes.
// Ports: clk, reset (async active-low), ps2_clk/ps2_data (raw pins),
//   code (last good byte), code_valid (1-cycle new byte), frame_err (1-cycle rejected frame).
// Optional: PS2_KEYS_PARITY_CHECK_EN enforces odd parity; otherwise the parity bit is ignored.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic          c1, c2, d1, d2, filt, fall;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0]    bcnt;
  logic [7:0]    sh;
  logic          par_ok;
  ps2_state_t    state;
`ifdef PS2_KEYS_PARITY_CHECK_EN
  logic par;
  assign par_ok = ^{sh, par};
`else
  assign par_ok = 1'b1;
`endif
  // fall is registered in the same cycle the filter commits to low, so the FSM acts one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {c1, c2, d1, d2} <= 4'hF;
      filt <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      c1 <= ps2_clk;
      c2 <= c1;
      d1 <= ps2_data;
      d2 <= d1;
      fall <= 1'b0;
      if (c2 == filt) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= c2;
        fcnt <= '0;
        fall <= filt;
      end else fcnt <= fcnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bcnt       <= '0;
      sh         <= '0;
      tcnt       <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_KEYS_PARITY_CHECK_EN
      par        <= 1'b0;
`endif
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (state)
          IDLE: if (!d2) begin
            state <= DATA;
            bcnt  <= '0;
          end
          DATA: begin
            sh    <= {d2, sh[7:1]};
            bcnt  <= bcnt + 3'd1;
            state <= (bcnt == 3'd7) ? PARITY : DATA;
          end
          PARITY: begin
`ifdef PS2_KEYS_PARITY_CHECK_EN
            par   <= d2;
`endif
            state <= STOP;
          end
          STOP: begin
            if (d2 && par_ok) begin
              code       <= sh;
              code_valid <= 1'b1;
            end else frame_err <= 1'b1;
            state <= IDLE;
          end
        endcase
      end else if (state != IDLE) begin
        // a stalled frame is silently dropped; a keyboard that stops mid-byte is not a framing error
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state <= IDLE;
          tcnt  <= '0;
        end else tcnt <= tcnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ps2_keys.sv
// ps2_keys: PS/2 keyboard receiver with make/break decoding into held up/down key levels.
// Ports: clk, reset (async active-low), ps2_clk/ps2_data (raw pins), code/code_valid/frame_err
//   (byte stream from the frame receiver), up (Up-arrow or Space held), down (Down-arrow held).
// Optional: PS2_KEYS_PARITY_CHECK_EN (see ps2_frame_rx).
module ps2_keys
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       up,
  output logic       down
);
  logic brk, ext;
  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .code_valid(code_valid), .frame_err(frame_err)
  );
  // prefix bytes only latch flags; the next non-prefix byte consumes and clears them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brk  <= 1'b0;
      ext  <= 1'b0;
      up   <= 1'b0;
      down <= 1'b0;
    end else if (code_valid) begin
      if (code == SC_BREAK) brk <= 1'b1;
      else if (code == SC_EXT) ext <= 1'b1;
      else begin
        up   <= ((ext && code == SC_UP) || (!ext && code == SC_SPACE)) ? !brk : up;
        down <= (ext && code == SC_DOWN) ? !brk : down;
        brk  <= 1'b0;
        ext  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ps2_keys.sv
// tb_ps2_keys: directed self-checking bench for ps2_keys with a shortened frame timeout.
module tb_ps2_keys;
  logic clk = 0, reset = 0, ps2_clk = 1, ps2_data = 1;
  logic [7:0] code;
  logic code_valid, frame_err, up, down;
  int passed = 0, total = 0;
  int cv_cnt = 0, fe_cnt = 0, both_cnt = 0, cyc = 0, fall_cyc = 0, cv_cyc = 0;

  ps2_keys #(.FILTER_LEN(8), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .code_valid(code_valid), .frame_err(frame_err), .up(up), .down(down)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (code_valid) begin
      cv_cnt++;
      cv_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
    if (code_valid && frame_err) both_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(3); ps2_clk = 0; wait_cyc(3); ps2_clk = 1; wait_cyc(4);
    end else wait_cyc(10);
    fall_cyc = cyc;
    ps2_clk = 0;
    wait_cyc(20);
    ps2_clk = 1;
    wait_cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    cv_cnt = 0;
    fe_cnt = 0;
    for (int i = 0; i < 11; i++) ps2_bit(f[i], glitch && i == 5);
    wait_cyc(20);
  endtask

  task automatic test_reset;
    wait_cyc(3);
    total++; if (code !== 8'h00) $display("FAIL reset_code got=%h exp=00", code); else passed++;
    total++; if ({code_valid, frame_err, up, down} !== 4'b0) $display("FAIL reset_flags got=%b exp=0000", {code_valid, frame_err, up, down}); else passed++;
    reset = 1;
    wait_cyc(5);
  endtask

  task automatic test_space;
    send_frame(8'h29, 0, 0, 0);
    total++; if (code !== 8'h29 || cv_cnt !== 1 || fe_cnt !== 0) $display("FAIL space_code got=%h/%0d/%0d exp=29/1/0", code, cv_cnt, fe_cnt); else passed++;
    total++; if (cv_cyc - fall_cyc !== 11) $display("FAIL latency got=%0d exp=11", cv_cyc - fall_cyc); else passed++;
    total++; if (up !== 1'b1) $display("FAIL space_up got=%b exp=1", up); else passed++;
    send_frame(8'hF0, 0, 0, 0);
    total++; if (up !== 1'b1 || cv_cnt !== 1) $display("FAIL break_prefix got=%b/%0d exp=1/1", up, cv_cnt); else passed++;
    send_frame(8'h29, 0, 0, 0);
    total++; if (up !== 1'b0 || cv_cnt !== 1) $display("FAIL space_break got=%b/%0d exp=0/1", up, cv_cnt); else passed++;
  endtask

  task automatic test_down;
    send_frame(8'hE0, 0, 0, 0);
    total++; if (cv_cnt !== 1 || down !== 1'b0) $display("FAIL ext_prefix got=%0d/%b exp=1/0", cv_cnt, down); else passed++;
    send_frame(8'h72, 0, 0, 0);
    total++; if (down !== 1'b1 || up !== 1'b0 || cv_cnt !== 1) $display("FAIL down_make got=%b/%b/%0d exp=1/0/1", down, up, cv_cnt); else passed++;
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    total++; if (down !== 1'b1 || cv_cnt !== 1) $display("FAIL down_prefixes got=%b/%0d exp=1/1", down, cv_cnt); else passed++;
    send_frame(8'h72, 0, 0, 0);
    total++; if (down !== 1'b0 || code !== 8'h72) $display("FAIL down_break got=%b/%h exp=0/72", down, code); else passed++;
  endtask

  task automatic test_parity;
    send_frame(8'h1C, 1, 0, 0);
`ifdef PS2_KEYS_PARITY_CHECK_EN
    total++; if (fe_cnt !== 1 || cv_cnt !== 0 || code !== 8'h72) $display("FAIL parity_err got=%0d/%0d/%h exp=1/0/72", fe_cnt, cv_cnt, code); else passed++;
`else
    total++; if (fe_cnt !== 0 || cv_cnt !== 1 || code !== 8'h1C) $display("FAIL parity_ignored got=%0d/%0d/%h exp=0/1/1c", fe_cnt, cv_cnt, code); else passed++;
`endif
  endtask

  task automatic test_stop;
    send_frame(8'h75, 0, 1, 0);
    total++; if (fe_cnt !== 1 || cv_cnt !== 0) $display("FAIL stop_err got=%0d/%0d exp=1/0", fe_cnt, cv_cnt); else passed++;
    send_frame(8'h75, 0, 0, 0);
    total++; if (code !== 8'h75 || cv_cnt !== 1 || up !== 1'b0) $display("FAIL plain_75 got=%h/%0d/%b exp=75/1/0", code, cv_cnt, up); else passed++;
  endtask

  task automatic test_timeout;
    cv_cnt = 0;
    fe_cnt = 0;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0);
    wait_cyc(1500);
    total++; if (cv_cnt !== 0 || fe_cnt !== 0) $display("FAIL timeout_quiet got=%0d/%0d exp=0/0", cv_cnt, fe_cnt); else passed++;
    send_frame(8'h29, 0, 0, 0);
    total++; if (code !== 8'h29 || cv_cnt !== 1 || fe_cnt !== 0 || up !== 1'b1) $display("FAIL timeout_recover got=%h/%0d/%0d/%b exp=29/1/0/1", code, cv_cnt, fe_cnt, up); else passed++;
  endtask

  task automatic test_glitch;
    send_frame(8'hF0, 0, 0, 1);
    total++; if (code !== 8'hF0 || cv_cnt !== 1 || fe_cnt !== 0) $display("FAIL glitch_f0 got=%h/%0d/%0d exp=f0/1/0", code, cv_cnt, fe_cnt); else passed++;
    send_frame(8'h29, 0, 0, 1);
    total++; if (code !== 8'h29 || cv_cnt !== 1 || up !== 1'b0) $display("FAIL glitch_29 got=%h/%0d/%b exp=29/1/0", code, cv_cnt, up); else passed++;
  endtask

  task automatic test_reset_mid;
    send_frame(8'h29, 0, 0, 0);
    total++; if (up !== 1'b1) $display("FAIL pre_reset_up got=%b exp=1", up); else passed++;
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    ps2_bit(1'b0, 0);
    reset = 0;
    #1;
    total++; if ({code, code_valid, frame_err, up, down} !== 12'h0) $display("FAIL reset_mid got=%h/%b/%b/%b/%b exp=0", code, code_valid, frame_err, up, down); else passed++;
    wait_cyc(3);
    reset = 1;
    wait_cyc(5);
    send_frame(8'h75, 0, 0, 0);
    total++; if (code !== 8'h75 || cv_cnt !== 1 || fe_cnt !== 0 || up !== 1'b0) $display("FAIL post_reset got=%h/%0d/%0d/%b exp=75/1/0/0", code, cv_cnt, fe_cnt, up); else passed++;
  endtask

  initial begin
    test_reset;
    test_space;
    test_down;
    test_parity;
    test_stop;
    test_timeout;
    test_glitch;
    test_reset_mid;
    total++; if (both_cnt !== 0) $display("FAIL exclusive_pulses got=%0d exp=0", both_cnt); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
